uart_sender: RTL and testbench

Buffered UART transmitter for the chip's serial output path. It accepts bytes from the core through a valid/ready push port into an internal FIFO of 2^BUF_WIDTH entries. It serializes them onto the TX line as 8N1 frames, one bit period every BIT_INTERVAL clocks. Its output drives the chip-level `uart_tx`, which the board registers once before the pin; it is the transmit counterpart of the chip's UART receiver.

---
 rtl/uart_sender.sv | 165 ++++++++++++++++
 tb/tb_uart_sender.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sender.sv
`default_nettype none
// ============================================================================
// Module      : uart_sender
// Description : Buffered 8N1 UART transmitter. A valid/ready push port feeds
//               a circular FIFO that is drained back-to-back onto uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sender #(
    parameter int BUF_WIDTH     = 10,
    parameter int BIT_INTERVAL  = 1302,
    parameter int STOP_INTERVAL = 1302
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [BUF_WIDTH:0]   count
);

    localparam int c_DEPTH = 1 << BUF_WIDTH;
    localparam int c_TMAX  = (STOP_INTERVAL > BIT_INTERVAL) ? STOP_INTERVAL : BIT_INTERVAL;
    localparam int c_TW    = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_TW-1:0]    c_BIT_LAST  = c_TW'(BIT_INTERVAL - 1);
    localparam logic [c_TW-1:0]    c_STOP_LAST = c_TW'(STOP_INTERVAL - 1);
    localparam logic [c_TW-1:0]    c_TIMER_ONE = c_TW'(1);
    localparam logic [BUF_WIDTH:0] c_FULL      = (BUF_WIDTH + 1)'(c_DEPTH);
    localparam logic [BUF_WIDTH:0] c_CNT_ONE   = (BUF_WIDTH + 1)'(1);
    localparam logic [BUF_WIDTH-1:0] c_PTR_ONE = BUF_WIDTH'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [7:0]           r_mem [0:c_DEPTH-1];
    logic [BUF_WIDTH-1:0] r_wptr;
    logic [BUF_WIDTH-1:0] r_rptr;
    logic [BUF_WIDTH:0]   r_count;

    logic [1:0]           r_state;
    logic [c_TW-1:0]      r_timer;
    logic [2:0]           r_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_not_empty;
    logic                 w_bit_done;
    logic                 w_stop_done;
    logic [7:0]           w_head;

    assign w_not_empty = (r_count != '0);
    assign w_bit_done  = (r_timer == c_BIT_LAST);
    assign w_stop_done = (r_timer == c_STOP_LAST);
    assign w_push      = in_valid && in_ready;
    // A pop happens either from idle or on the final stop clock, which is
    // what lets consecutive frames run with no idle gap.
    assign w_pop       = w_not_empty &&
                         ((r_state == c_IDLE) || ((r_state == c_STOP) && w_stop_done));
    assign w_head      = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_timer <= '0;
                        r_tx    <= 1'b0;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= c_DATA;
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end
                c_DATA: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end else begin
                            // Drive the next bit now so the line changes on the boundary.
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_idx   <= r_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end
                c_STOP: begin
                    if (w_stop_done) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= c_START;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = (r_count != c_FULL);
    assign uart_tx  = r_tx;
    assign busy     = (r_state != c_IDLE) || w_not_empty;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_sender
// Description : Directed self-checking bench for uart_sender (BIT=4 bench).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sender;

    logic       clk = 1'b0;
    logic       reset;
    logic       v1, v2;
    logic [7:0] d1, d2;
    logic       rdy1, tx1, busy1;
    logic       rdy2, tx2, busy2;
    logic [2:0] cnt1, cnt2;

    int checks   = 0;
    int failures = 0;
    int mon_err  = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_sender #(.BUF_WIDTH(2), .BIT_INTERVAL(4), .STOP_INTERVAL(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1),
        .in_ready(rdy1), .uart_tx(tx1), .busy(busy1), .count(cnt1)
    );

    uart_sender #(.BUF_WIDTH(2), .BIT_INTERVAL(4), .STOP_INTERVAL(7)) u_dut_stretch (
        .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2),
        .in_ready(rdy2), .uart_tx(tx2), .busy(busy2), .count(cnt2)
    );

    // Line decoder for u_dut: samples each bit in its middle; frames cut by reset are dropped.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx1 === 1'b0) begin
                logic [7:0] b;
                bit abort;
                bit bad;
                b = '0; abort = 0; bad = 0;
                for (int k = 1; k <= 38; k++) begin
                    @(negedge clk);
                    if (reset !== 1'b0) abort = 1;
                    if (k == 2 && tx1 !== 1'b0) bad = 1;
                    if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) b[(k - 6) / 4] = tx1;
                    if (k == 38 && tx1 !== 1'b1) bad = 1;
                end
                if (!abort) begin
                    rx_q.push_back(b);
                    if (bad) mon_err++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy1 === 1'b0) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; v1 = 1'b0; d1 = '0; v2 = 1'b0; d2 = '0;
        repeat (3) @(negedge clk);
        checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx1); end
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rdy1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", cnt1); end
        checks++; if (tx2 !== 1'b1) begin failures++; $display("FAIL reset_tx2: got %b expected 1", tx2); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        v1 = 1'b1; d1 = 8'hA5;
        @(negedge clk);
        v1 = 1'b0;
        checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL single_count_accept: got %0d expected 1", cnt1); end
        checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL single_tx_accept: got %b expected 1", tx1); end
        @(negedge clk);
        checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL single_count_pop: got %0d expected 0", cnt1); end
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (tx1 !== fr[k / 4]) begin
                failures++; $display("FAIL single_line cycle %0d: got %b expected %b", k, tx1, fr[k / 4]);
            end
        end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL single_busy_stop: got %b expected 1", busy1); end
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL single_busy_idle: got %b expected 0", busy1); end
        checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL single_tx_idle: got %b expected 1", tx1); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [9:0] fr0, fr1;
        logic exp;
        bit ok;
        fr0 = {1'b1, 8'h00, 1'b0};
        fr1 = {1'b1, 8'hFF, 1'b0};
        rx_q.delete();
        v1 = 1'b1; d1 = 8'h00;
        @(negedge clk);
        d1 = 8'hFF;
        checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL b2b_count_first: got %0d expected 1", cnt1); end
        @(negedge clk);
        v1 = 1'b0;
        checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL b2b_count_overlap: got %0d expected 1", cnt1); end
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clk);
            exp = (k < 40) ? fr0[k / 4] : fr1[(k - 40) / 4];
            checks++;
            if (tx1 !== exp) begin
                failures++; $display("FAIL b2b_line cycle %0d: got %b expected %b", k, tx1, exp);
            end
            if (k == 39) begin
                checks++; if (cnt1 !== 3'd1) begin failures++; $display("FAIL b2b_count_before: got %0d expected 1", cnt1); end
            end
            if (k == 40) begin
                checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL b2b_count_after: got %0d expected 0", cnt1); end
            end
        end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_idle_timeout: busy=%b expected 0", busy1); end
        checks++; if (rx_q.size() != 2) begin failures++; $display("FAIL b2b_frames: got %0d frames expected 2", rx_q.size()); end
    endtask

    task automatic test_full;
        logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp_rx  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bit ok;
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            v1 = 1'b1; d1 = 8'((i + 1) * 8'h11);
            @(negedge clk);
            checks++; if (cnt1 !== exp_cnt[i]) begin failures++; $display("FAIL full_count push %0d: got %0d expected %0d", i, cnt1, exp_cnt[i]); end
            checks++; if (rdy1 !== exp_rdy[i]) begin failures++; $display("FAIL full_ready push %0d: got %b expected %b", i, rdy1, exp_rdy[i]); end
        end
        v1 = 1'b0;
        // Now 4 cycles into the first frame; the first FIFO pop is at the end of its stop bit.
        repeat (35) @(negedge clk);
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL full_ready_before_pop: got %b expected 0", rdy1); end
        @(negedge clk);
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop: got %b expected 1", rdy1); end
        checks++; if (cnt1 !== 3'd3) begin failures++; $display("FAIL full_count_after_pop: got %0d expected 3", cnt1); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_idle_timeout: busy=%b expected 0", busy1); end
        checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL full_frames: got %0d frames expected 5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_rx[i]) begin
                failures++; $display("FAIL full_byte %0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_rx[i]);
            end
        end
    endtask

    task automatic test_wrap;
        int sent;
        bit ok;
        sent = 0;
        rx_q.delete();
        for (int cyc = 0; cyc < 3000 && sent < 11; cyc++) begin
            if (rdy1 === 1'b1) begin
                v1 = 1'b1; d1 = 8'(sent + 1);
            end else begin
                v1 = 1'b0;
            end
            @(negedge clk);
            if (v1) sent++;
        end
        v1 = 1'b0;
        checks++; if (sent != 11) begin failures++; $display("FAIL wrap_push_timeout: got %0d pushes expected 11", sent); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_idle_timeout: busy=%b expected 0", busy1); end
        checks++; if (rx_q.size() != 11) begin failures++; $display("FAIL wrap_frames: got %0d frames expected 11", rx_q.size()); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== 8'(i + 1)) begin
                failures++; $display("FAIL wrap_byte %0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i + 1));
            end
        end
        checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL wrap_count_end: got %0d expected 0", cnt1); end
    endtask

    task automatic test_reset_mid;
        int lows;
        bit ok;
        rx_q.delete();
        v1 = 1'b1; d1 = 8'h3C;
        @(negedge clk);
        d1 = 8'h77;
        @(negedge clk);
        d1 = 8'h88;
        @(negedge clk);
        v1 = 1'b0;
        checks++; if (cnt1 !== 3'd2) begin failures++; $display("FAIL rst_mid_count_queued: got %0d expected 2", cnt1); end
        repeat (15) @(negedge clk);
        // Inside D3 of 0x3C, which is a 1.
        checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL rst_mid_d3: got %b expected 1", tx1); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL rst_mid_tx: got %b expected 1", tx1); end
        checks++; if (cnt1 !== 3'd0) begin failures++; $display("FAIL rst_mid_count: got %0d expected 0", cnt1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy1); end
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", lows); end
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL rst_mid_no_frames: got %0d frames expected 0", rx_q.size()); end
        v1 = 1'b1; d1 = 8'h5A;
        @(negedge clk);
        v1 = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_mid_idle_timeout: busy=%b expected 0", busy1); end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
            failures++; $display("FAIL rst_mid_fresh: got %0d frames first %h expected 1 frame 5a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        checks++; if (mon_err != 0) begin failures++; $display("FAIL frame_format: got %0d bad frames expected 0", mon_err); end
    endtask

    task automatic test_stop_stretch;
        logic [7:0] dat;
        logic exp;
        int o;
        int run;
        bit in_run;
        dat = 8'h55;
        run = 0; in_run = 0;
        v2 = 1'b1; d2 = 8'h55;
        @(negedge clk);
        @(negedge clk);
        v2 = 1'b0;
        // Each frame: 4 start + 32 data + 7 stop = 43 clocks.
        for (int k = 0; k < 86; k++) begin
            if (k > 0) @(negedge clk);
            o = (k < 43) ? k : k - 43;
            exp = (o < 4) ? 1'b0 : (o < 36) ? dat[(o - 4) / 4] : 1'b1;
            checks++;
            if (tx2 !== exp) begin
                failures++; $display("FAIL stretch_line cycle %0d: got %b expected %b", k, tx2, exp);
            end
            if (k == 36) in_run = 1;
            if (in_run && k < 60) begin
                if (tx2 === 1'b1) run++;
                else in_run = 0;
            end
        end
        checks++; if (run != 7) begin failures++; $display("FAIL stretch_stop_len: got %0d clocks expected 7", run); end
        @(negedge clk);
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL stretch_busy_idle: got %b expected 0", busy2); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_full;
        test_wrap;
        test_reset_mid;
        test_stop_stretch;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
